fetch_stage: RTL and testbench

- Instruction fetch stage directly downstream of the program counter.
- Accepts the PC address each cycle and reads a local synchronous instruction memory.
- Presents the fetched instruction and its PC to decode through a valid/ready handshake.
- Drives the PC-advance enable, absorbs branch flushes, and owns the IDLE/RUN/HALT run state.

---
 rtl/glorb_pkg.sv | 16 +
 rtl/fetch_stage_if.sv | 13 +
 rtl/imem_sync.sv | 28 ++
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/glorb_pkg.sv
// Shared definitions for the fetch stage: run-state encoding and the HALT opcode.
package glorb_pkg;

    localparam int IW_DEFAULT  = 8;
    localparam int IMW_DEFAULT = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_RUN  = 2'b01,
        FETCH_HALT = 2'b10
    } fetch_state_e;

    // HALT is the all-ones instruction; bit 0 is replicated to any width.
    localparam logic [IW_DEFAULT-1:0] HALT_OP = '1;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch -> decode instruction handshake (valid/ready).
interface fetch_stage_if #(
    parameter int IW  = 8,
    parameter int IMW = 4
);
    logic [IW-1:0]  instr_o;
    logic [IMW-1:0] instr_pc_o;
    logic           instr_valid_o;
    logic           instr_ready_i;

    modport master (output instr_o, output instr_pc_o, output instr_valid_o, input  instr_ready_i);
    modport slave  (input  instr_o, input  instr_pc_o, input  instr_valid_o, output instr_ready_i);
endinterface

// File: rtl/imem_sync.sv
// 2**IMW x IW instruction RAM: one write port, synchronous registered read.
// A read and write of the same address at one edge returns the old word.
module imem_sync #(
    parameter int IW  = 8,
    parameter int IMW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [IMW-1:0] waddr,
    input  logic [IW-1:0]  wdata,
    input  logic           re,
    input  logic [IMW-1:0] raddr,
    output logic [IW-1:0]  rdata
);
    logic [IW-1:0] mem [2**IMW];

    // Program-load write port; array contents survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register only advances on a fetch so it can hold a stalled word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: read stage R (RAM read register) feeding output
// stage O toward decode, plus the IDLE/RUN/HALT run state.
// Optional: define FETCH_HALT_DETECT_EN to stop fetching on a HALT opcode.
module fetch_stage
    import glorb_pkg::*;
#(
    parameter int IW  = IW_DEFAULT,
    parameter int IMW = IMW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           flush,
    input  logic [IMW-1:0] pc_addr,
    output logic           fetch_req_o,
    input  logic           prog_we,
    input  logic [IMW-1:0] prog_addr,
    input  logic [IW-1:0]  prog_data,
    output logic           run_o,
    output logic           halt_o,
    fetch_stage_if.master  dec
);
    fetch_state_e   state, state_nxt;
    logic           rd_v;
    logic [IMW-1:0] rd_pc;
    logic [IW-1:0]  rd_data;
    logic           o_free, r_moves, halt_hit;

    assign o_free      = !dec.instr_valid_o || dec.instr_ready_i;
    assign r_moves     = rd_v && o_free;
    assign fetch_req_o = (state == FETCH_RUN) && !flush && (!rd_v || o_free);

`ifdef FETCH_HALT_DETECT_EN
    // A HALT word entering O stops the stage; a same-cycle flush wins.
    assign halt_hit = r_moves && !flush && (rd_data == {IW{HALT_OP[0]}});
`else
    assign halt_hit = 1'b0;
`endif

    imem_sync #(.IW(IW), .IMW(IMW)) u_imem (
        .clk   (clk),
        .rst   (rst),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (fetch_req_o),
        .raddr (pc_addr),
        .rdata (rd_data)
    );

    // Run-state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH_IDLE;
        else     state <= state_nxt;
    end

    // Run-state transitions; the unused encoding falls back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_IDLE: if (start)    state_nxt = FETCH_RUN;
            FETCH_RUN:  if (halt_hit) state_nxt = FETCH_HALT;
            FETCH_HALT: if (start)    state_nxt = FETCH_RUN;
            default:                  state_nxt = FETCH_IDLE;
        endcase
    end

    // Run-state decoded outputs.
    always_comb begin
        run_o = (state == FETCH_RUN);
`ifdef FETCH_HALT_DETECT_EN
        halt_o = (state == FETCH_HALT);
`else
        halt_o = 1'b0;
`endif
    end

    // R valid/pc: fetch fills it, a move to O empties it, flush or halt drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_v  <= 1'b0;
            rd_pc <= '0;
        end else if (flush) begin
            rd_v  <= 1'b0;
        end else if (fetch_req_o) begin
            rd_v  <= !halt_hit;
            rd_pc <= pc_addr;
        end else if (r_moves) begin
            rd_v  <= 1'b0;
        end
    end

    // O stage: load from R, retire on handshake, otherwise hold stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec.instr_valid_o <= 1'b0;
            dec.instr_o       <= '0;
            dec.instr_pc_o    <= '0;
        end else if (flush) begin
            dec.instr_valid_o <= 1'b0;
        end else if (r_moves) begin
            dec.instr_valid_o <= 1'b1;
            dec.instr_o       <= rd_data;
            dec.instr_pc_o    <= rd_pc;
        end else if (dec.instr_valid_o && dec.instr_ready_i) begin
            dec.instr_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the fetch pipeline.
module tb_fetch_stage;
    localparam int IW  = 8;
    localparam int IMW = 4;
`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0, flush = 1'b0, prog_we = 1'b0;
    logic [IMW-1:0] pc_addr = '0, prog_addr = '0;
    logic [IW-1:0]  prog_data = '0;
    logic           fetch_req_o, run_o, halt_o;

    fetch_stage_if #(.IW(IW), .IMW(IMW)) dec();

    fetch_stage #(.IW(IW), .IMW(IMW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .flush       (flush),
        .pc_addr     (pc_addr),
        .fetch_req_o (fetch_req_o),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .run_o       (run_o),
        .halt_o      (halt_o),
        .dec         (dec)
    );

    always #5 clk = ~clk;

    // Model: words fetched but not yet retired, oldest first. Only the head
    // can be on display, and only after it has spent one edge in flight.
    typedef struct { logic [IW-1:0] d; logic [IMW-1:0] p; } item_t;
    item_t          q[$];
    bit             head_vis;
    int             mstate;          // 0 idle, 1 run, 2 halt
    logic [IW-1:0]  mmem [16];
    logic [IMW-1:0] pc, flush_tgt;
    logic           req_seen;
    int             n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit st, input bit fl, input bit rdy,
                        input bit we, input logic [IMW-1:0] wa, input logic [IW-1:0] wd);
        bit    exp_valid, pending, ofree, exp_req, halted;
        item_t nf;
        start = st; flush = fl; dec.instr_ready_i = rdy;
        prog_we = we; prog_addr = wa; prog_data = wd; pc_addr = pc;
        exp_valid = (q.size() > 0) && head_vis;
        pending   = q.size() > (head_vis ? 1 : 0);
        ofree     = !exp_valid || rdy;
        exp_req   = (mstate == 1) && !fl && (!pending || ofree);
        #1;
        check("fetch_req", 32'(fetch_req_o), 32'(exp_req));
        check("instr_valid", 32'(dec.instr_valid_o), 32'(exp_valid));
        if (exp_valid) begin
            check("instr", 32'(dec.instr_o), 32'(q[0].d));
            check("instr_pc", 32'(dec.instr_pc_o), 32'(q[0].p));
        end
        check("run", 32'(run_o), 32'(mstate == 1));
        check("halt", 32'(halt_o), 32'(mstate == 2));
        req_seen = fetch_req_o;
        @(posedge clk);
        nf.d = mmem[pc]; nf.p = pc;
        if (we) mmem[wa] = wd;
        halted = 1'b0;
        if (fl) begin
            q.delete();
            head_vis = 1'b0;
        end else begin
            if (exp_valid && rdy) begin
                void'(q.pop_front());
                head_vis = 1'b0;
            end
            if (ofree && q.size() > 0) begin
                head_vis = 1'b1;
                if (HALT_EN && q[0].d == 8'hFF) begin
                    halted = 1'b1;
                    while (q.size() > 1) void'(q.pop_back());
                end
            end
            if (exp_req && !halted) q.push_back(nf);
        end
        if ((mstate == 0 || mstate == 2) && st) mstate = 1;
        else if (mstate == 1 && halted)       mstate = 2;
        if (fl)           pc = flush_tgt;
        else if (exp_req) pc = pc + 1'b1;
        #1;
    endtask

    task automatic s(input bit st, input bit fl, input bit rdy);
        step(st, fl, rdy, 1'b0, '0, '0);
    endtask

    task automatic lit_o(input string name, input logic [IW-1:0] d, input logic [IMW-1:0] p);
        check({name, "_valid"}, 32'(dec.instr_valid_o), 32'd1);
        check({name, "_instr"}, 32'(dec.instr_o), 32'(d));
        check({name, "_pc"}, 32'(dec.instr_pc_o), 32'(p));
    endtask

    initial begin
        logic [IW-1:0]  exp_s [4];
        logic [IMW-1:0] a;
        logic [IW-1:0]  wd;
        exp_s = '{8'h11, 8'h22, 8'h33, 8'h44};
        dec.instr_ready_i = 1'b0;
        mstate = 0; head_vis = 1'b0; pc = '0; flush_tgt = '0;

        // Reset state
        #2;
        check("rst_valid", 32'(dec.instr_valid_o), 32'd0);
        check("rst_instr", 32'(dec.instr_o), 32'd0);
        check("rst_req", 32'(fetch_req_o), 32'd0);
        check("rst_run", 32'(run_o), 32'd0);
        check("rst_halt", 32'(halt_o), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Program load: 0x11..0x44 at 0..3, then a*0x11 (5 -> 0x55, 8 -> 0x88)
        for (int i = 0; i < 16; i++) begin
            a  = i[IMW-1:0];
            wd = (i < 4) ? 8'((i + 1) * 17) : 8'(i * 17);
            step(0, 0, 1, 1, a, wd);
        end

        // Load and stream
        pc = '0;
        s(1, 0, 1);
        s(0, 0, 1);
        check("first_req", 32'(req_seen), 32'd1);
        check("first_not_yet_valid", 32'(dec.instr_valid_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            s(0, 0, 1);
            lit_o("stream", exp_s[k], k[IMW-1:0]);
        end

        // Backpressure while 0x22 is presented
        flush_tgt = 4'd1; s(0, 1, 1);
        check("flush_clears", 32'(dec.instr_valid_o), 32'd0);
        s(0, 0, 1);
        s(0, 0, 1);
        lit_o("bp_pre", 8'h22, 4'd1);
        for (int k = 0; k < 3; k++) begin
            s(0, 0, 0);
            check("bp_req", 32'(req_seen), 32'd0);
            lit_o("bp_hold", 8'h22, 4'd1);
        end
        s(0, 0, 1);
        lit_o("bp_next", 8'h33, 4'd2);
        s(0, 0, 1);
        lit_o("bp_next2", 8'h44, 4'd3);

        // Flush with 0x22 presented and 0x33 in R
        flush_tgt = 4'd1; s(0, 1, 1);
        s(0, 0, 1);
        s(0, 0, 1);
        lit_o("fl_pre", 8'h22, 4'd1);
        flush_tgt = 4'd8; s(0, 1, 0);
        check("fl_req", 32'(req_seen), 32'd0);
        check("fl_valid", 32'(dec.instr_valid_o), 32'd0);
        s(0, 0, 1);
        s(0, 0, 1);
        lit_o("fl_target", 8'h88, 4'd8);

        // Write/read collision on address 5
        flush_tgt = 4'd5; s(0, 1, 1);
        step(0, 0, 1, 1, 4'd5, 8'hAA);
        s(0, 0, 1);
        lit_o("coll_old", 8'h55, 4'd5);
        flush_tgt = 4'd5; s(0, 1, 1);
        s(0, 0, 1);
        s(0, 0, 1);
        lit_o("coll_new", 8'hAA, 4'd5);

        // Asynchronous reset mid-run with a valid word on display
        start = 1'b0; flush = 1'b0; prog_we = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(dec.instr_valid_o), 32'd0);
        check("arst_instr", 32'(dec.instr_o), 32'd0);
        check("arst_pc", 32'(dec.instr_pc_o), 32'd0);
        check("arst_req", 32'(fetch_req_o), 32'd0);
        check("arst_run", 32'(run_o), 32'd0);
        q.delete(); head_vis = 1'b0; mstate = 0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // HALT opcode at address 2
        step(0, 0, 1, 1, 4'd2, 8'hFF);
        pc = '0;
        s(1, 0, 1);
        s(0, 0, 1);
        s(0, 0, 1);
        s(0, 0, 1);
        s(0, 0, 1);
        lit_o("halt_word", 8'hFF, 4'd2);
        check("halt_flag", 32'(halt_o), 32'(HALT_EN));
        check("halt_run", 32'(run_o), 32'(!HALT_EN));
        s(0, 0, 0);
        if (HALT_EN) begin
            check("halt_noreq", 32'(req_seen), 32'd0);
            s(0, 0, 1);
            s(1, 0, 1);
            s(0, 0, 1);
            s(0, 0, 1);
            lit_o("halt_resume", 8'h44, 4'd4);
        end

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            bit st, fl, rdy, we;
            st  = ($urandom_range(0, 9) == 0);
            fl  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            we  = ($urandom_range(0, 4) == 0);
            if (fl) flush_tgt = IMW'($urandom);
            wd = ($urandom_range(0, 7) == 0) ? 8'hFF : IW'($urandom);
            step(st, fl, rdy, we, IMW'($urandom), wd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
